mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports (instruction fetch, load/store) and the
// single-ported memory port served by mem_arbiter.
interface mem_arbiter_if #(
  parameter int XLEN = 32
) ();

  logic            if_req_valid;
  logic            if_req_ready;
  logic [XLEN-1:0] if_addr;
  logic            if_rsp_valid;
  logic [XLEN-1:0] if_rsp_data;

  logic            ls_req_valid;
  logic            ls_req_ready;
  logic            ls_req_we;
  logic [XLEN-1:0] ls_addr;
  logic [XLEN-1:0] ls_wdata;
  logic            ls_rsp_valid;
  logic [XLEN-1:0] ls_rsp_data;

  logic            mem_read_en;
  logic            mem_write_en;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  // Environment side: requesters plus the memory returning read data.
  modport master (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_req_we, ls_addr, ls_wdata,
    output mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_read_en, mem_write_en, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_req_we, ls_addr, ls_wdata,
    input  mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_read_en, mem_write_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store; each access is handshake -> ACCESS -> RESP (2-cycle latency).
module mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic ID_IF = 1'b0;
  localparam logic ID_LS = 1'b1;

  state_t          state_q;
  state_t          state_d;
  logic            prio_q;
  logic            accept;
  logic            grant_if;
  logic            grant_ls;
  logic            hs;

  logic            id_p1;
  logic            we_p1;
  logic [XLEN-1:0] addr_p1;
  logic [XLEN-1:0] wdata_p1;
  logic [XLEN-1:0] if_rsp_p2;
  logic [XLEN-1:0] ls_rsp_p2;

  // Grant is purely combinational so a requester sees ready in the same cycle
  // it raises valid; the pointer only breaks ties when both are asking.
  always_comb begin
    accept   = (state_q != ACCESS) && !rst;
    grant_if = accept && bus.if_req_valid && (!bus.ls_req_valid || prio_q == ID_IF);
    grant_ls = accept && bus.ls_req_valid && (!bus.if_req_valid || prio_q == ID_LS);
    hs       = grant_if || grant_ls;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = hs ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: request captured at handshake; stage p2: response captured at
  // the closing edge of ACCESS. Reset drops an in-flight access silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= ID_IF;
      id_p1     <= ID_IF;
      we_p1     <= 1'b0;
      if_rsp_p2 <= '0;
      ls_rsp_p2 <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        prio_q <= grant_if ? ID_LS : ID_IF;
        id_p1  <= grant_if ? ID_IF : ID_LS;
        we_p1  <= grant_ls && bus.ls_req_we;
      end
      if (state_q == ACCESS) begin
        if (id_p1 == ID_IF) begin
          if_rsp_p2 <= bus.mem_rdata;
        end else begin
          ls_rsp_p2 <= we_p1 ? '0 : bus.mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      addr_p1  <= grant_if ? bus.if_addr : bus.ls_addr;
      wdata_p1 <= grant_if ? '0 : bus.ls_wdata;
    end
  end

  assign bus.if_req_ready = grant_if;
  assign bus.ls_req_ready = grant_ls;

  assign bus.if_rsp_valid = (state_q == RESP) && (id_p1 == ID_IF);
  assign bus.ls_rsp_valid = (state_q == RESP) && (id_p1 == ID_LS);
  assign bus.if_rsp_data  = if_rsp_p2;
  assign bus.ls_rsp_data  = ls_rsp_p2;

  // Memory port is driven only during ACCESS; writes are masked by reset.
  assign bus.mem_read_en  = (state_q == ACCESS) && !we_p1;
  assign bus.mem_write_en = (state_q == ACCESS) && we_p1 && !rst;
  assign bus.mem_addr     = (state_q == ACCESS) ? addr_p1 : '0;
  assign bus.mem_wdata    = (state_q == ACCESS) ? wdata_p1 : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural word memory plus a linear
// sequence of requests with hand-computed expected responses.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic mem_clr;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-word memory; unwritten words read back a fixed pattern.
  logic [31:0] mem     [64];
  logic        written [64];

  function automatic logic [31:0] init_val(input int i);
    return (i == 5) ? 32'hDEAD_BEEF : (32'hA000_0000 + 32'(i));
  endfunction

  function automatic logic [31:0] mem_rd(input int i);
    return written[i] ? mem[i] : init_val(i);
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) written[i] <= 1'b0;
    end else if (bus.mem_write_en) begin
      mem[int'(bus.mem_addr[5:0])]     <= bus.mem_wdata;
      written[int'(bus.mem_addr[5:0])] <= 1'b1;
    end
  end

  assign bus.mem_rdata = mem_rd(int'(bus.mem_addr[5:0]));

  int n_pass;
  int n_chk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_if;
    n_pass = 0;
    n_chk  = 0;
    rst = 1'b1;
    mem_clr = 1'b1;
    bus.if_req_valid = 1'b0;
    bus.if_addr      = '0;
    bus.ls_req_valid = 1'b0;
    bus.ls_req_we    = 1'b0;
    bus.ls_addr      = '0;
    bus.ls_wdata     = '0;

    tick();
    tick();
    mem_clr = 1'b0;

    // Reset state, and ready held low while rst is high.
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'd5;
    #1;
    chk("rst_if_ready", 32'(bus.if_req_ready), 32'd0);
    chk("rst_rsp_valid", {30'd0, bus.if_rsp_valid, bus.ls_rsp_valid}, 32'd0);
    chk("rst_if_rsp_data", bus.if_rsp_data, 32'd0);
    chk("rst_ls_rsp_data", bus.ls_rsp_data, 32'd0);
    chk("rst_mem_read_en", 32'(bus.mem_read_en), 32'd0);

    // Single fetch of addr 5.
    rst = 1'b0;
    #1;
    chk("if_ready", {30'd0, bus.if_req_ready, bus.ls_req_ready}, 32'b10);
    tick();
    bus.if_req_valid = 1'b0;
    #1;
    chk("if_acc_read_en", 32'(bus.mem_read_en), 32'd1);
    chk("if_acc_addr", bus.mem_addr, 32'd5);
    chk("if_acc_ready", 32'(bus.if_req_ready), 32'd0);
    chk("if_acc_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
    tick();
    chk("if_rsp_valid", {30'd0, bus.if_rsp_valid, bus.ls_rsp_valid}, 32'b10);
    chk("if_rsp_data", bus.if_rsp_data, 32'hDEAD_BEEF);
    chk("resp_mem_idle", {bus.mem_addr[29:0], bus.mem_read_en, bus.mem_write_en}, 32'd0);
    tick();
    chk("if_rsp_pulse", 32'(bus.if_rsp_valid), 32'd0);
    chk("if_rsp_hold", bus.if_rsp_data, 32'hDEAD_BEEF);

    // Store 0x12345678 to addr 9, then back-to-back load of addr 9.
    bus.ls_req_valid = 1'b1;
    bus.ls_req_we    = 1'b1;
    bus.ls_addr      = 32'd9;
    bus.ls_wdata     = 32'h1234_5678;
    #1;
    chk("st_ready", 32'(bus.ls_req_ready), 32'd1);
    tick();
    bus.ls_req_valid = 1'b0;
    #1;
    chk("st_write_en", {30'd0, bus.mem_write_en, bus.mem_read_en}, 32'b10);
    chk("st_addr", bus.mem_addr, 32'd9);
    chk("st_wdata", bus.mem_wdata, 32'h1234_5678);
    tick();
    chk("st_rsp_valid", 32'(bus.ls_rsp_valid), 32'd1);
    chk("st_rsp_data", bus.ls_rsp_data, 32'd0);
    chk("st_mem_9", mem_rd(9), 32'h1234_5678);
    bus.ls_req_valid = 1'b1;
    bus.ls_req_we    = 1'b0;
    #1;
    chk("ld_ready_in_resp", 32'(bus.ls_req_ready), 32'd1);
    tick();
    bus.ls_req_valid = 1'b0;
    tick();
    chk("ld_rsp_valid", 32'(bus.ls_rsp_valid), 32'd1);
    chk("ld_rsp_data", bus.ls_rsp_data, 32'h1234_5678);
    tick();
    chk("ld_rsp_pulse", 32'(bus.ls_rsp_valid), 32'd0);

    // Valid dropped before any edge leaves no access behind.
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'd7;
    #1;
    bus.if_req_valid = 1'b0;
    tick();
    chk("drop_no_access", {30'd0, bus.mem_read_en, bus.if_rsp_valid}, 32'd0);

    // Fresh reset, then both requesters valid continuously for 8 grants.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.if_addr      = 32'd1;
    bus.ls_addr      = 32'd2;
    bus.ls_req_we    = 1'b0;
    bus.if_req_valid = 1'b1;
    bus.ls_req_valid = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_if = (k % 2 == 0);
      chk($sformatf("rr_ready_%0d", k), {30'd0, bus.if_req_ready, bus.ls_req_ready},
          {30'd0, exp_if, !exp_if});
      tick();
      chk($sformatf("rr_acc_ready_%0d", k), {30'd0, bus.if_req_ready, bus.ls_req_ready}, 32'd0);
      tick();
      chk($sformatf("rr_rsp_%0d", k), {30'd0, bus.if_rsp_valid, bus.ls_rsp_valid},
          {30'd0, exp_if, !exp_if});
      if (exp_if) chk($sformatf("rr_if_data_%0d", k), bus.if_rsp_data, 32'hA000_0001);
      else        chk($sformatf("rr_ls_data_%0d", k), bus.ls_rsp_data, 32'hA000_0002);
    end
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    tick();
    chk("rr_idle", {30'd0, bus.if_rsp_valid, bus.ls_rsp_valid}, 32'd0);

    // Store aborted by reset during its ACCESS cycle.
    bus.ls_req_valid = 1'b1;
    bus.ls_req_we    = 1'b1;
    bus.ls_addr      = 32'd20;
    bus.ls_wdata     = 32'hCAFE_F00D;
    #1;
    chk("ab_ready", 32'(bus.ls_req_ready), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("ab_write_en", 32'(bus.mem_write_en), 32'd0);
    bus.if_req_valid = 1'b1;
    tick();
    chk("ab_ready_rst", {30'd0, bus.if_req_ready, bus.ls_req_ready}, 32'd0);
    chk("ab_no_rsp", 32'(bus.ls_rsp_valid), 32'd0);
    chk("ab_rsp_data_clr", bus.ls_rsp_data, 32'd0);
    chk("ab_mem_20", mem_rd(20), 32'hA000_0014);
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("ab_no_rsp_late", {30'd0, bus.if_rsp_valid, bus.ls_rsp_valid}, 32'd0);

    // LS request raised while a fetch occupies ACCESS.
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'd3;
    #1;
    chk("hold_if_ready", 32'(bus.if_req_ready), 32'd1);
    tick();
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_we    = 1'b0;
    bus.ls_addr      = 32'd4;
    #1;
    chk("hold_ls_ready_acc", 32'(bus.ls_req_ready), 32'd0);
    tick();
    chk("hold_if_rsp", 32'(bus.if_rsp_valid), 32'd1);
    chk("hold_if_data", bus.if_rsp_data, 32'hA000_0003);
    chk("hold_ls_ready_resp", 32'(bus.ls_req_ready), 32'd1);
    tick();
    bus.ls_req_valid = 1'b0;
    #1;
    chk("hold_ls_acc", {bus.mem_addr[30:0], bus.mem_read_en}, {31'd4, 1'b1});
    tick();
    chk("hold_ls_rsp", 32'(bus.ls_rsp_valid), 32'd1);
    chk("hold_ls_data", bus.ls_rsp_data, 32'hA000_0004);
    tick();
    chk("hold_ls_pulse", 32'(bus.ls_rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
